// File: rtl/display_glyphs_pkg.sv
// Shared glyph definitions for the 7-segment display path.
// Segment bit order: bit0 = a ... bit6 = g, 1 = segment lit.
// The same table drives the display encoder, so both sides agree on every glyph.
package display_glyphs_pkg;

    localparam int GLYPH_COUNT = 16;

    // Team glyphs and the blank code
    localparam logic [3:0] CODE_TEAM_H = 4'd11;
    localparam logic [3:0] CODE_TEAM_L = 4'd12;
    localparam logic [3:0] CODE_TEAM_P = 4'd13;
    localparam logic [3:0] CODE_BLANK  = 4'd15;

    // Lit-segment pattern per glyph code; codes 10 and 14 have no glyph
    localparam logic [6:0] GLYPH_TABLE [GLYPH_COUNT] = '{
        7'h3F,  // 0
        7'h06,  // 1
        7'h5B,  // 2
        7'h4F,  // 3
        7'h66,  // 4
        7'h6D,  // 5
        7'h7D,  // 6
        7'h07,  // 7
        7'h7F,  // 8
        7'h6F,  // 9
        7'h00,  // 10 unused
        7'h76,  // 11 team glyph H
        7'h38,  // 12 team glyph L
        7'h73,  // 13 team glyph P
        7'h00,  // 14 unused
        7'h00   // 15 blank
    };

    // Which codes own a real table entry
    localparam logic [15:0] GLYPH_DEFINED = 16'b1011_1011_1111_1111;

    typedef enum logic [1:0] {
        READER_IDLE   = 2'd0,
        READER_SETTLE = 2'd1,
        READER_HOLD   = 2'd2
    } reader_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } glyph_decode_t;

    // Reverse lookup: lit pattern to glyph code, valid only on an exact match
    function automatic glyph_decode_t decode_glyph(input logic [6:0] pattern);
        glyph_decode_t result;
        result.valid = 1'b0;
        result.code  = CODE_BLANK;
        for (int i = 0; i < GLYPH_COUNT; i++) begin
            if (GLYPH_DEFINED[i] && (GLYPH_TABLE[i] == pattern)) begin
                result.valid = 1'b1;
                result.code  = 4'(i);
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seven_segment_reader_input_synchronizer.sv
// input_synchronizer: plain two-flop synchronizer for a bus of
// quasi-static inputs. Bits are synchronized independently; the reader
// tolerates skew between bits through its stability counter.
module input_synchronizer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_data,
    output logic [WIDTH-1:0] sync_data
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;

    // two-stage capture of the asynchronous bus
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta_r <= RESET_VALUE;
            sync_r <= RESET_VALUE;
        end else begin
            meta_r <= async_data;
            sync_r <= meta_r;
        end
    end

    assign sync_data = sync_r;

endmodule

// File: rtl/seven_segment_reader.sv
// seven_segment_reader: monitors a multiplexed 4-digit 7-segment display bus,
// waits for each digit slot to settle, decodes it back to a glyph code and
// publishes complete frames on digit_3..digit_0 with a frame_valid strobe.
// Optional build macro: SEVEN_SEGMENT_READER_TIMEOUT_EN enables the
// no-frame timeout that drives 'stalled'; otherwise 'stalled' is tied low.
module seven_segment_reader
    import display_glyphs_pkg::*;
#(
    parameter int STABLE_CYCLES      = 4,
    parameter int SEGMENT_ACTIVE_LOW = 0,
    parameter int TIMEOUT_CYCLES     = 65535
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [6:0] segments,
    input  logic [3:0] display_enables,
    input  logic       clear_errors,
    output logic [3:0] digit_3,
    output logic [3:0] digit_2,
    output logic [3:0] digit_1,
    output logic [3:0] digit_0,
    output logic       frame_valid,
    output logic       pattern_error,
    output logic       enable_conflict,
    output logic       stalled
);

    generate
        if (STABLE_CYCLES < 2) begin : g_bad_stable
            $error("seven_segment_reader: STABLE_CYCLES must be at least 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("seven_segment_reader: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    localparam int               CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);

    // enables idle high, segments dark: the bus looks empty out of reset
    localparam logic [10:0] BUS_IDLE = {4'hF, 7'h00};

    logic [10:0]        raw_bus_s;
    logic [10:0]        sync_bus_s;
    logic [10:0]        prev_bus_r;
    logic [3:0]         enables_s;
    logic [3:0]         low_mask_s;
    logic [6:0]         lit_s;
    logic               same_s;
    logic               any_low_s;
    logic               one_low_s;
    glyph_decode_t      decoded_s;

    reader_state_t      state_r;
    reader_state_t      state_next_s;
    logic [CNT_W-1:0]   stable_cnt_r;
    logic [CNT_W-1:0]   stable_cnt_next_s;
    logic               accept_s;
    logic               pattern_bad_s;
    logic               conflict_s;

    logic [3:0]         seen_r;
    logic [3:0]         seen_next_s;
    logic               frame_pulse_s;
    logic [3:0]         slot_buf_r [4];
    logic [3:0]         frame_r    [4];
    logic               frame_valid_r;
    logic               pattern_error_r;
    logic               enable_conflict_r;

    assign raw_bus_s = {display_enables, segments};

    input_synchronizer #(
        .WIDTH       (11),
        .RESET_VALUE (BUS_IDLE)
    ) u_bus_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .async_data (raw_bus_s),
        .sync_data  (sync_bus_s)
    );

    assign enables_s  = sync_bus_s[10:7];
    assign lit_s      = (SEGMENT_ACTIVE_LOW != 0) ? ~sync_bus_s[6:0] : sync_bus_s[6:0];
    assign low_mask_s = ~enables_s;
    assign any_low_s  = (low_mask_s != 4'd0);
    assign one_low_s  = any_low_s && ((low_mask_s & (low_mask_s - 4'd1)) == 4'd0);
    assign same_s     = (sync_bus_s == prev_bus_r);
    assign decoded_s  = decode_glyph(lit_s);

    assign frame_pulse_s = &seen_r;

    // previous synchronized sample for the stability comparison
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_bus_r <= BUS_IDLE;
        end else begin
            prev_bus_r <= sync_bus_s;
        end
    end

    // state and stability counter registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= READER_IDLE;
            stable_cnt_r <= CNT_ZERO;
        end else begin
            state_r      <= state_next_s;
            stable_cnt_r <= stable_cnt_next_s;
        end
    end

    // next-state logic: settle, accept/reject, hold until the bus changes
    always_comb begin
        state_next_s      = state_r;
        stable_cnt_next_s = stable_cnt_r;
        accept_s          = 1'b0;
        pattern_bad_s     = 1'b0;
        conflict_s        = 1'b0;
        case (state_r)
            READER_IDLE: begin
                if (any_low_s) begin
                    // this sample is the first of the settling run
                    state_next_s      = READER_SETTLE;
                    stable_cnt_next_s = CNT_ONE;
                end else begin
                    stable_cnt_next_s = CNT_ZERO;
                end
            end
            READER_SETTLE: begin
                if (!any_low_s) begin
                    state_next_s      = READER_IDLE;
                    stable_cnt_next_s = CNT_ZERO;
                end else if (!same_s) begin
                    stable_cnt_next_s = CNT_ONE;
                end else if (stable_cnt_r == CNT_LAST) begin
                    stable_cnt_next_s = CNT_MAX;
                    if (one_low_s) begin
                        state_next_s = READER_HOLD;
                        if (decoded_s.valid) begin
                            accept_s = 1'b1;
                        end else begin
                            pattern_bad_s = 1'b1;
                        end
                    end else begin
                        // several enables low: flag it and wait here for a change
                        conflict_s = 1'b1;
                    end
                end else if (stable_cnt_r < CNT_MAX) begin
                    stable_cnt_next_s = stable_cnt_r + CNT_ONE;
                end else begin
                    stable_cnt_next_s = stable_cnt_r;
                end
            end
            READER_HOLD: begin
                if (!same_s) begin
                    if (any_low_s) begin
                        state_next_s      = READER_SETTLE;
                        stable_cnt_next_s = CNT_ONE;
                    end else begin
                        state_next_s      = READER_IDLE;
                        stable_cnt_next_s = CNT_ZERO;
                    end
                end else begin
                    state_next_s = READER_HOLD;
                end
            end
            default: begin
                state_next_s      = READER_IDLE;
                stable_cnt_next_s = CNT_ZERO;
            end
        endcase
    end

    // seen bits: a completed frame clears them, an accept marks its slot
    always_comb begin
        seen_next_s = seen_r;
        if (frame_pulse_s) begin
            seen_next_s = 4'h0;
        end else begin
            seen_next_s = seen_r;
        end
        if (accept_s) begin
            seen_next_s = seen_next_s | low_mask_s;
        end else begin
            seen_next_s = seen_next_s;
        end
    end

    // slot buffer, seen bits and the published frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            seen_r        <= 4'h0;
            frame_valid_r <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                slot_buf_r[i] <= CODE_BLANK;
                frame_r[i]    <= CODE_BLANK;
            end
        end else begin
            seen_r        <= seen_next_s;
            frame_valid_r <= frame_pulse_s;
            for (int i = 0; i < 4; i++) begin
                if (accept_s && low_mask_s[i]) begin
                    slot_buf_r[i] <= decoded_s.code;
                end else begin
                    slot_buf_r[i] <= slot_buf_r[i];
                end
                if (frame_pulse_s) begin
                    frame_r[i] <= slot_buf_r[i];
                end else begin
                    frame_r[i] <= frame_r[i];
                end
            end
        end
    end

    // sticky error flags; a new error beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pattern_error_r   <= 1'b0;
            enable_conflict_r <= 1'b0;
        end else begin
            if (pattern_bad_s) begin
                pattern_error_r <= 1'b1;
            end else if (clear_errors) begin
                pattern_error_r <= 1'b0;
            end else begin
                pattern_error_r <= pattern_error_r;
            end
            if (conflict_s) begin
                enable_conflict_r <= 1'b1;
            end else if (clear_errors) begin
                enable_conflict_r <= 1'b0;
            end else begin
                enable_conflict_r <= enable_conflict_r;
            end
        end
    end

`ifdef SEVEN_SEGMENT_READER_TIMEOUT_EN
    localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] timeout_cnt_r;
    logic             stalled_r;

    // saturating cycles-since-last-frame counter and stall level
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt_r <= {TMO_W{1'b0}};
            stalled_r     <= 1'b0;
        end else if (frame_pulse_s) begin
            timeout_cnt_r <= {TMO_W{1'b0}};
            stalled_r     <= 1'b0;
        end else if (timeout_cnt_r < TMO_MAX) begin
            timeout_cnt_r <= timeout_cnt_r + TMO_ONE;
            stalled_r     <= ((timeout_cnt_r + TMO_ONE) == TMO_MAX);
        end else begin
            timeout_cnt_r <= timeout_cnt_r;
            stalled_r     <= 1'b1;
        end
    end

    assign stalled = stalled_r;
`else
    assign stalled = 1'b0;
`endif

    assign digit_3         = frame_r[3];
    assign digit_2         = frame_r[2];
    assign digit_1         = frame_r[1];
    assign digit_0         = frame_r[0];
    assign frame_valid     = frame_valid_r;
    assign pattern_error   = pattern_error_r;
    assign enable_conflict = enable_conflict_r;

endmodule

// File: doc/seven_segment_reader.md
# seven_segment_reader

Receive-side counterpart of the multiplexed 7-segment display path: watches the shared segment lines and active-low digit enables, waits for each digit slot to settle, decodes the lit pattern back into a 4-bit glyph code, and assembles complete four-digit frames. It sits beside the display pins, on-board as a self-check monitor or in the bench as a scoreboard front end, and reports decoded digits, frame strobes and protocol errors.

## Interface
Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a digit is accepted (min 2).
- SEGMENT_ACTIVE_LOW, 0: 1 = segment lit when line low.
- TIMEOUT_CYCLES, 65535: cycles without a completed frame before `stalled` (timeout build only).

Ports:
- clock  in  1  system clock; all sampling on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- segments  in  7  bit0 = a … bit6 = g, polarity per SEGMENT_ACTIVE_LOW.
- display_enables  in  4  active-low digit enables, bit3 = leftmost digit.
- digit_3, digit_2, digit_1, digit_0  out  4 each  last completed frame, glyph codes.
- frame_valid  out  1  one-cycle strobe: new frame latched onto digit_* outputs.
- pattern_error  out  1  sticky: settled pattern matched no glyph.
- enable_conflict  out  1  sticky: more than one enable low on a settled sample.
- stalled  out  1  level: no frame for TIMEOUT_CYCLES (tied 0 without timeout build).
- clear_errors  in  1  synchronous clear of sticky flags.

## Operation
- Inputs pass a 2-flop synchronizer; all logic below uses synchronized values.
- States: IDLE (no enable low) -> SETTLE (exactly one enable low, counting) -> HOLD (digit accepted, waiting for enables/segments to change) -> back to IDLE or SETTLE.
- SETTLE: stability counter increments while {enables, segments} equal the previous sample; any change restarts it at 1. At STABLE_CYCLES, decode and go to HOLD.
- Decode: exact match against glyph table (codes 0–9 decimal, 11, 12, 13 team glyphs); blank pattern (all off) = code 15. No match -> pattern_error set, slot not marked seen.
- Accepted digit stored in slot buffer; slot's seen bit set. Re-capture of an already-seen slot overwrites it.
- When all four seen bits set: copy buffer to digit_* outputs, pulse frame_valid, clear seen bits, same cycle.
- Two or more enables low and stable for STABLE_CYCLES: enable_conflict set, no capture, stay in SETTLE until change.
- clear_errors and new error same cycle: error wins (flag stays set).

## Timing
- Reset: digit_* = 4'hF, frame_valid = 0, pattern_error = 0, enable_conflict = 0, stalled = 0, seen bits cleared, state IDLE, counters 0.
- Latency: input change to accept = 2 (sync) + STABLE_CYCLES clocks; last accept to frame_valid = 1 clock.
- Reset mid-frame discards partial buffer; first frame after reset needs all four slots.
- Stability counter saturates at STABLE_CYCLES; no wrap.
- Timeout counter width clog2(TIMEOUT_CYCLES+1), saturating; cleared on every frame_valid.

## Configuration
- SEVEN_SEGMENT_READER_TIMEOUT_EN defined: timeout counter built; stalled rises the cycle the count reaches TIMEOUT_CYCLES and falls on next frame_valid or reset.
- Undefined: no counter, stalled constant 0, TIMEOUT_CYCLES ignored.

## Structure
- Shared package display_glyphs_pkg: 7-bit glyph pattern table indexed by code (single source shared with display_decoder), code constants for blank/team glyphs, reader state typedef.
- One sub-module: input_synchronizer (2-flop, parameterized width), instantiated for segments+enables.

## Test plan
- Scan 1,2,3,4 (codes on digits 3..0), each slot held 8 clocks, STABLE_CYCLES=4 -> frame_valid once; digit_3..0 = 1,2,3,4; no errors.
- Segment glitch lasting 2 clocks mid-slot -> counter restarts, correct value still captured; no pattern_error.
- Settled pattern 7'b1010101 (no glyph) on digit_1 -> pattern_error=1, no frame until slot re-sent validly; clear_errors -> 0.
- Enables 4'b0011 held 10 clocks -> enable_conflict=1, no capture.
- Assert reset_n low after 2 slots captured, then full scan -> outputs 4'hF during reset; single frame only after all four slots.
- Timeout build, TIMEOUT_CYCLES=100, enables held 4'b1111 -> stalled=1 at cycle 100; next full frame -> stalled=0.
